// File: rtl/mc_alu_sequencer.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/wb,
// drives ALU op and operand selects, datapath enables, retire counter.
module mc_alu_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_J_EX     = 4'd12
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1010;

  state_t     st, nxt;
  logic       bad, retire;
  logic       f_ok;
  logic [3:0] f_op;
  logic       is_lw, is_sw, is_r;
  logic       is_beq, is_addi, is_j;

  assign state   = st;
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_r    = (opcode == 6'b000000);
  assign is_beq  = (opcode == 6'b000100);
  assign is_addi = (opcode == 6'b001000);
  assign is_j    = (opcode == 6'b000010);

  always_comb begin
    f_ok = 1'b1;
    f_op = OP_ADD;
    case (funct)
      6'b100000: f_op = OP_ADD;
      6'b100010: f_op = OP_SUB;
      6'b100100: f_op = OP_AND;
      6'b100101: f_op = OP_OR;
      6'b101010: f_op = OP_SLT;
      6'b100111: f_op = OP_NOR;
      default:   f_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt        = st;
    bad        = 1'b0;
    retire     = 1'b0;
    alu_op     = OP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (st)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          is_lw | is_sw: nxt = S_MEMADR;
          is_r & f_ok:   nxt = S_RTYPE_EX;
          is_beq:        nxt = S_BEQ_EX;
          is_addi:       nxt = S_ADDI_EX;
          is_j:          nxt = S_J_EX;
          default: begin
            nxt = S_FETCH;
            bad = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        if (mem_ready) nxt = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = f_op;
        nxt       = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BEQ_EX: begin
        alu_src_a = 1'b1;
        alu_op    = OP_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_J_EX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st      <= S_IDLE;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      st <= nxt;
      if (bad) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Directed bench for mc_alu_sequencer: walks each instruction class
// and checks state, strobes and counters against hand-computed values.
module tb_mc_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic [3:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic        pc_en, ir_write, iord;
  logic        mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mc_alu_sequencer #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state(state),
    .retired(retired)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rtype(input logic [5:0] f,
                       input logic [3:0] op,
                       input logic [31:0] ret0);
    opcode = 6'b000000;
    funct  = f;
    check("r_fetch", state, 1);
    tick();
    check("r_decode", state, 2);
    check("r_dec_srcb", alu_src_b, 3);
    tick();
    check("r_ex", state, 7);
    check("r_ex_op", alu_op, op);
    check("r_ex_srca", alu_src_a, 1);
    tick();
    check("r_wb", state, 8);
    check("r_wb_rw", reg_write, 1);
    check("r_wb_dst", reg_dst, 1);
    check("r_wb_nowr", mem_write, 0);
    tick();
    check("r_back", state, 1);
    check("r_ret", retired, ret0 + 1);
  endtask

  task automatic beq(input logic z,
                     input logic [31:0] ret0);
    opcode = 6'b000100;
    tick();
    check("b_decode", state, 2);
    tick();
    zero = z;
    #1;
    check("b_ex", state, 9);
    check("b_pcen", pc_en, z);
    check("b_pcsrc", pc_src, 1);
    check("b_op", alu_op, 4'b0110);
    tick();
    zero = 1'b0;
    check("b_back", state, 1);
    check("b_ret", retired, ret0 + 1);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b0;
    funct     = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    tick(2);
    check("rst_state", state, 0);
    check("rst_memrd", mem_read, 0);
    check("rst_pcen", pc_en, 0);
    check("rst_irw", ir_write, 0);
    check("rst_op", alu_op, 4'b0010);
    check("rst_ret", retired, 0);
    check("rst_ill", illegal, 0);
    reset = 1'b0;
    tick();
    check("fetch_state", state, 1);
    check("fetch_irw", ir_write, 1);
    check("fetch_pcen", pc_en, 1);
    check("fetch_op", alu_op, 4'b0010);
    check("fetch_srcb", alu_src_b, 1);
    check("fetch_rd", mem_read, 1);

    rtype(6'b100010, 4'b0110, 0);
    rtype(6'b100111, 4'b1010, 1);
    rtype(6'b101010, 4'b0111, 2);
    check("ret_after_r", retired, 3);

    beq(1'b1, 3);
    beq(1'b0, 4);

    // lw with three stalled cycles in MEMRD
    opcode = 6'b100011;
    tick();
    check("lw_decode", state, 2);
    tick();
    check("lw_adr", state, 3);
    check("lw_adr_srca", alu_src_a, 1);
    check("lw_adr_srcb", alu_src_b, 2);
    tick();
    check("lw_rd", state, 4);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_hold", state, 4);
      check("lw_hold_iord", iord, 1);
      check("lw_hold_rd", mem_read, 1);
    end
    mem_ready = 1'b1;
    tick();
    check("lw_wb", state, 5);
    check("lw_wb_rw", reg_write, 1);
    check("lw_wb_m2r", mem_to_reg, 1);
    check("lw_wb_nowr", mem_write, 0);
    tick();
    check("lw_back", state, 1);
    check("lw_ret", retired, 6);

    opcode = 6'b001000;
    tick(2);
    check("addi_ex", state, 10);
    check("addi_srcb", alu_src_b, 2);
    tick();
    check("addi_wb", state, 11);
    check("addi_rw", reg_write, 1);
    check("addi_dst", reg_dst, 0);
    tick();
    check("addi_ret", retired, 7);

    opcode = 6'b000010;
    tick(2);
    check("j_ex", state, 12);
    check("j_pcen", pc_en, 1);
    check("j_pcsrc", pc_src, 2);
    tick();
    check("j_back", state, 1);
    check("j_ret", retired, 8);

    opcode = 6'b111111;
    tick();
    check("ill_decode", state, 2);
    check("ill_pre", illegal, 0);
    tick();
    check("ill_back", state, 1);
    check("ill_set", illegal, 1);
    check("ill_ret", retired, 8);

    opcode = 6'b000000;
    funct  = 6'b000000;
    tick();
    check("illf_decode", state, 2);
    tick();
    check("illf_back", state, 1);
    check("illf_sticky", illegal, 1);
    check("illf_ret", retired, 8);

    // sw, then reset while waiting on memory
    opcode = 6'b101011;
    tick(3);
    check("sw_wr", state, 6);
    mem_ready = 1'b0;
    tick();
    check("sw_hold", state, 6);
    check("sw_wr_strb", mem_write, 1);
    check("sw_iord", iord, 1);
    reset = 1'b1;
    tick();
    check("mrst_state", state, 0);
    check("mrst_wr", mem_write, 0);
    check("mrst_ret", retired, 0);
    check("mrst_ill", illegal, 0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("mrst_fetch", state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
